// File: rtl/user_ip_apb_switch_if.sv
// -----------------------------------------------------------------------------
// user_ip_apb_switch_if
// APB4 bus bundle shared by the upstream port and the downstream user-IP ports
// of user_ip_apb_switch.
//   master modport : drives the request (paddr, pprot, psel, penable, pwrite,
//                    pwdata, pstrb); receives the response (pready, prdata,
//                    pslverr).
//   slave modport  : receives the request; drives the response.
// Also provides the default width of the user-IP select bus.
// -----------------------------------------------------------------------------
`ifndef USER_IPSEL_WIDTH
`define USER_IPSEL_WIDTH 2
`endif

interface user_ip_apb_switch_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/user_ip_apb_switch.sv
// -----------------------------------------------------------------------------
// user_ip_apb_switch
// Routes one upstream APB4 slave port to one of NUM_SLV downstream user IPs.
// The target index is latched from sel_i only while the bus is idle, selects
// beyond NUM_SLV are answered locally with an error, and a transfer whose
// downstream pready stays low for TIMEOUT_CYC access cycles is aborted.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   sel_i          : requested downstream index
//   apb            : upstream APB4 port (slave modport)
//   slv[NUM_SLV]   : downstream APB4 ports (master modport)
//   busy_o         : transfer in progress
//   timeout_o      : one-cycle pulse in the abort cycle
//   abort_cnt_o    : saturating count of timeouts and decode errors
// -----------------------------------------------------------------------------
module user_ip_apb_switch #(
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [`USER_IPSEL_WIDTH-1:0] sel_i,
  user_ip_apb_switch_if.slave          apb,
  user_ip_apb_switch_if.master         slv [NUM_SLV],
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic [7:0]                   abort_cnt_o
);

  localparam int unsigned SEL_W  = `USER_IPSEL_WIDTH;
  localparam int unsigned NSEL   = 1 << SEL_W;
  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [SEL_W-1:0]  sel_q;

  // Per-index response view; indices at or above NUM_SLV are unpopulated.
  logic [NSEL-1:0]   slot_ok;
  logic [NSEL-1:0]   rsp_ready;
  logic [NSEL-1:0]   rsp_err;
  logic [DATA_W-1:0] rsp_rdata [NSEL];

  logic              dec_err;
  logic              rt_ready;
  logic              rt_err;
  logic [DATA_W-1:0] rt_rdata;
  logic              wdt_hit;
  logic              fwd_en;
  logic              abort_inc;
  logic              up_ready;
  logic              up_err;
  logic [DATA_W-1:0] up_rdata;

  // Downstream request fan-out and response gather, one slot per select value.
  for (genvar g = 0; g < int'(NSEL); g++) begin : g_slot
    if (g < int'(NUM_SLV)) begin : g_used
      logic hit;
      // Reset gating drops every downstream strobe as soon as rst_n_i falls.
      assign hit = rst_n_i && (sel_q == SEL_W'(g));

      assign slv[g].paddr   = hit ? apb.paddr  : '0;
      assign slv[g].pprot   = hit ? apb.pprot  : '0;
      assign slv[g].pwrite  = hit && apb.pwrite;
      assign slv[g].pwdata  = hit ? apb.pwdata : '0;
      assign slv[g].pstrb   = hit ? apb.pstrb  : '0;
      assign slv[g].psel    = hit && fwd_en && apb.psel;
      assign slv[g].penable = hit && fwd_en && apb.penable;

      assign slot_ok[g]   = 1'b1;
      assign rsp_ready[g] = slv[g].pready;
      assign rsp_err[g]   = slv[g].pslverr;
      assign rsp_rdata[g] = slv[g].prdata;
    end else begin : g_unused
      assign slot_ok[g]   = 1'b0;
      assign rsp_ready[g] = 1'b0;
      assign rsp_err[g]   = 1'b0;
      assign rsp_rdata[g] = '0;
    end
  end

  // Routed port: local error responder stands in for unpopulated indices.
  assign dec_err  = !slot_ok[sel_q];
  assign rt_ready = dec_err || rsp_ready[sel_q];
  assign rt_err   = dec_err || rsp_err[sel_q];
  assign rt_rdata = dec_err ? '0 : rsp_rdata[sel_q];

  // Stall watchdog, absent when TIMEOUT_CYC is 0.
  if (TIMEOUT_CYC != 0) begin : g_wdt
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        wdt_cnt <= '0;
      end else if (state_q == ST_IDLE) begin
        wdt_cnt <= '0;
      end else if (state_q == ST_XFER && !rt_ready) begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
    end

    assign wdt_hit = (wdt_cnt == WDT_W'(TIMEOUT_CYC - 1));
  end else begin : g_no_wdt
    assign wdt_hit = 1'b0;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (apb.psel && !apb.penable) state_d = ST_XFER;
      ST_XFER: begin
        if (rt_ready) begin
          state_d = ST_IDLE;
        end else if (wdt_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: upstream response and request forwarding enable.
  always_comb begin
    up_ready  = 1'b0;
    up_err    = 1'b0;
    up_rdata  = '0;
    fwd_en    = 1'b1;
    busy_o    = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_XFER: begin
        busy_o   = 1'b1;
        up_ready = rt_ready;
        up_err   = rt_err;
        up_rdata = rt_rdata;
      end
      ST_ERR: begin
        busy_o    = 1'b1;
        timeout_o = 1'b1;
        fwd_en    = 1'b0;
        up_ready  = 1'b1;
        up_err    = 1'b1;
      end
      default: ;
    endcase
  end

  assign apb.pready  = up_ready;
  assign apb.pslverr = up_err;
  assign apb.prdata  = up_rdata;

  // Select only moves while the bus is fully idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q <= '0;
    end else if (state_q == ST_IDLE && !apb.psel) begin
      sel_q <= sel_i;
    end
  end

  // Abort counter: timeout entry or a completed decode-error transfer.
  assign abort_inc = (state_q == ST_XFER) && ((state_d == ST_ERR) || dec_err);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      abort_cnt_o <= '0;
    end else if (abort_inc && abort_cnt_o != CNT_MAX) begin
      abort_cnt_o <= abort_cnt_o + 8'd1;
    end
  end

endmodule
